// File: rtl/timed_traffic_ctrl.sv
// Two-road (NS/EW) traffic-light controller with per-phase dwell timers,
// all-red clearance and a latched pedestrian request served by a WALK phase.
// All outputs are registered decodes of the next state, so they always
// match the current state register with no combinational path from inputs.
module timed_traffic_ctrl #(
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned GREEN_T  = 10,
    parameter int unsigned YELLOW_T = 3,
    parameter int unsigned ALLRED_T = 1,
    parameter int unsigned WALK_T   = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_en,
    input  logic       ped_req,
    output logic [2:0] light_ns,
    output logic [2:0] light_ew,
    output logic       walk,
    output logic       ped_ack,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        StNsG  = 3'd0,
        StNsY  = 3'd1,
        StAr1  = 3'd2,
        StEwG  = 3'd3,
        StEwY  = 3'd4,
        StAr2  = 3'd5,
        StWalk = 3'd6
    } state_e;

    localparam logic [2:0] LampRed    = 3'b100;
    localparam logic [2:0] LampYellow = 3'b010;
    localparam logic [2:0] LampGreen  = 3'b001;

    // Kept as a plain vector so the unused code 7 is representable and recoverable.
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ped_pend_q, ped_pend_d;
    logic             nxt_ns_q, nxt_ns_d;
    logic             enter_walk;

    logic [2:0] light_ns_d, light_ew_d, phase_d;
    logic       walk_d, ped_ack_d;

    // Dwell reload value (DUR-1) for the state being entered.
    function automatic logic [CNT_W-1:0] load_val(input logic [2:0] s);
        case (s)
            StNsG, StEwG: load_val = CNT_W'(GREEN_T - 1);
            StNsY, StEwY: load_val = CNT_W'(YELLOW_T - 1);
            StWalk:       load_val = CNT_W'(WALK_T - 1);
            default:      load_val = CNT_W'(ALLRED_T - 1);
        endcase
    endfunction

    // Next-state, dwell counter and pedestrian latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        nxt_ns_d   = nxt_ns_q;
        enter_walk = 1'b0;
        if (state_q == 3'd7) begin
            // Recover through a full all-red clearance.
            state_d = StAr1;
            cnt_d   = load_val(StAr1);
        end else if (tick_en) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end else begin
                case (state_q)
                    StNsG: state_d = StNsY;
                    StNsY: state_d = StAr1;
                    StAr1: begin
                        if (ped_pend_q) begin
                            state_d    = StWalk;
                            nxt_ns_d   = 1'b0;
                            enter_walk = 1'b1;
                        end else begin
                            state_d = StEwG;
                        end
                    end
                    StEwG: state_d = StEwY;
                    StEwY: state_d = StAr2;
                    StAr2: begin
                        if (ped_pend_q) begin
                            state_d    = StWalk;
                            nxt_ns_d   = 1'b1;
                            enter_walk = 1'b1;
                        end else begin
                            state_d = StNsG;
                        end
                    end
                    StWalk:  state_d = nxt_ns_q ? StNsG : StEwG;
                    default: state_d = StAr1;
                endcase
                cnt_d = load_val(state_d);
            end
        end
        // Entering WALK consumes the request; a press on that same clk merges into it.
        if (enter_walk) begin
            ped_pend_d = 1'b0;
        end else if (ped_req && (state_q != StWalk)) begin
            ped_pend_d = 1'b1;
        end else begin
            ped_pend_d = ped_pend_q;
        end
    end

    // Moore output decode of the state about to be entered.
    always_comb begin
        light_ns_d = LampRed;
        light_ew_d = LampRed;
        walk_d     = 1'b0;
        ped_ack_d  = enter_walk;
        phase_d    = state_d;
        case (state_d)
            StNsG:   light_ns_d = LampGreen;
            StNsY:   light_ns_d = LampYellow;
            StEwG:   light_ew_d = LampGreen;
            StEwY:   light_ew_d = LampYellow;
            StWalk:  walk_d     = 1'b1;
            default: ;
        endcase
    end

    // State, timer and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StNsG;
            cnt_q      <= CNT_W'(GREEN_T - 1);
            ped_pend_q <= 1'b0;
            nxt_ns_q   <= 1'b0;
            light_ns   <= LampGreen;
            light_ew   <= LampRed;
            walk       <= 1'b0;
            ped_ack    <= 1'b0;
            phase      <= 3'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ped_pend_q <= ped_pend_d;
            nxt_ns_q   <= nxt_ns_d;
            light_ns   <= light_ns_d;
            light_ew   <= light_ew_d;
            walk       <= walk_d;
            ped_ack    <= ped_ack_d;
            phase      <= phase_d;
        end
    end

endmodule
